iq_pingpong_ram: RTL and testbench

IQ_PINGPONG_RAM -- requirements
Module: iq_pingpong_ram

---
 rtl/iq_pingpong_ram.sv | 110 +++++++++++
 tb/tb_iq_pingpong_ram.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iq_pingpong_ram.sv
// rtl/iq_pingpong_ram.sv - two-bank ping-pong complex sample buffer with frame handoff
module iq_pingpong_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 14,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic signed [DATA_W-1:0] wr_re,
    input  logic signed [DATA_W-1:0] wr_im,
    output logic [ADDR_W-1:0]        wr_cnt,
    output logic                     frame_rdy,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_re,
    output logic signed [DATA_W-1:0] rd_im,
    output logic                     rd_valid,
    output logic                     rd_err,
    input  logic                     rd_done,
    output logic                     wr_bank,
    output logic                     rd_bank
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    logic [2*DATA_W-1:0] mem0 [DEPTH];
    logic [2*DATA_W-1:0] mem1 [DEPTH];

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_acc;
    logic       wr_last;
    logic       rd_rel;
    logic       rd_legal;

    assign wr_ready  = ~full[wr_bank];
    assign frame_rdy = full[rd_bank];
    assign wr_acc    = wr_valid & wr_ready;
    assign wr_last   = wr_acc & (wr_cnt == LAST_ADDR);
    assign rd_rel    = rd_done & frame_rdy;
    assign rd_legal  = rd_en & frame_rdy & ({1'b0, rd_addr} < DEPTH_X);

    // A completing write and a release never target the same bank, so both apply.
    always_comb begin
        full_nxt = full;
        if (rd_rel) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_acc) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_rel) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            if (wr_bank) begin
                mem1[wr_cnt] <= {wr_re, wr_im};
            end else begin
                mem0[wr_cnt] <= {wr_re, wr_im};
            end
        end
    end

    // Read uses the pre-toggle rd_bank, so a read alongside rd_done sees the released frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_re    <= '0;
            rd_im    <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_legal;
            rd_err   <= rd_en & ~rd_legal;
            if (rd_legal) begin
                if (rd_bank) begin
                    {rd_re, rd_im} <= mem1[rd_addr];
                end else begin
                    {rd_re, rd_im} <= mem0[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_pingpong_ram.sv
// tb/tb_iq_pingpong_ram.sv - directed self-checking bench for iq_pingpong_ram
module tb_iq_pingpong_ram;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_valid;
    logic               wr_ready;
    logic signed [15:0] wr_re;
    logic signed [15:0] wr_im;
    logic [3:0]         wr_cnt;
    logic               frame_rdy;
    logic               rd_en;
    logic [3:0]         rd_addr;
    logic signed [15:0] rd_re;
    logic signed [15:0] rd_im;
    logic               rd_valid;
    logic               rd_err;
    logic               rd_done;
    logic               wr_bank;
    logic               rd_bank;

    int errors = 0;
    int checks = 0;

    iq_pingpong_ram #(.DATA_W(16), .DEPTH(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_re(wr_re), .wr_im(wr_im),
        .wr_cnt(wr_cnt), .frame_rdy(frame_rdy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im),
        .rd_valid(rd_valid), .rd_err(rd_err), .rd_done(rd_done),
        .wr_bank(wr_bank), .rd_bank(rd_bank)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        errors++;
        $error("FAIL timeout: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int re, input int im);
        wr_valid = 1'b1;
        wr_re    = 16'(re);
        wr_im    = 16'(im);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int addr);
        rd_en   = 1'b1;
        rd_addr = 4'(addr);
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_re = '0; wr_im = '0;
        rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_frame_rdy", frame_rdy, 1'b0);
        chk("rst_wr_cnt", wr_cnt, 4'd0);
        chk("rst_wr_bank", wr_bank, 1'b0);
        chk("rst_rd_bank", rd_bank, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_rd_re", rd_re, 16'sd0);

        for (int k = 0; k < 13; k++) wr(k, -k);
        chk("wr13_cnt", wr_cnt, 4'd13);
        chk("wr13_frame_rdy", frame_rdy, 1'b0);
        wr(13, -13);
        chk("wr14_frame_rdy", frame_rdy, 1'b1);
        chk("wr14_wr_bank", wr_bank, 1'b1);
        chk("wr14_wr_cnt", wr_cnt, 4'd0);
        chk("wr14_wr_ready", wr_ready, 1'b1);

        rd(5);
        chk("rd5_valid", rd_valid, 1'b1);
        chk("rd5_re", rd_re, 16'sd5);
        chk("rd5_im", rd_im, -16'sd5);
        chk("rd5_err", rd_err, 1'b0);
        tick();
        chk("idle_valid", rd_valid, 1'b0);
        chk("idle_hold_re", rd_re, 16'sd5);

        rd(14);
        chk("addr14_err", rd_err, 1'b1);
        chk("addr14_valid", rd_valid, 1'b0);
        chk("addr14_hold_re", rd_re, 16'sd5);
        chk("addr14_hold_im", rd_im, -16'sd5);
        tick();
        chk("addr14_err_pulse", rd_err, 1'b0);

        for (int k = 0; k < 14; k++) wr(100 + k, -(100 + k));
        chk("both_full_wr_ready", wr_ready, 1'b0);
        chk("both_full_wr_bank", wr_bank, 1'b0);
        wr_valid = 1'b1; wr_re = 16'sh7777; wr_im = 16'sh7777;
        tick(); tick(); tick();
        wr_valid = 1'b0;
        chk("blocked_wr_cnt", wr_cnt, 4'd0);
        chk("blocked_wr_ready", wr_ready, 1'b0);
        rd(0);
        chk("no_overwrite_re0", rd_re, 16'sd0);
        rd(13);
        chk("no_overwrite_re13", rd_re, 16'sd13);
        chk("no_overwrite_im13", rd_im, -16'sd13);

        rd_done = 1'b1;
        rd(3);
        rd_done = 1'b0;
        chk("rd_done_read_re", rd_re, 16'sd3);
        chk("rd_done_read_im", rd_im, -16'sd3);
        chk("rd_done_rd_bank", rd_bank, 1'b1);
        chk("rd_done_wr_ready", wr_ready, 1'b1);
        chk("rd_done_frame_rdy", frame_rdy, 1'b1);
        rd(3);
        chk("bank1_re3", rd_re, 16'sd103);

        for (int k = 0; k < 13; k++) wr(200 + k, -(200 + k));
        rd_done = 1'b1;
        wr(213, -213);
        rd_done = 1'b0;
        chk("swap_a_frame_rdy", frame_rdy, 1'b1);
        chk("swap_a_rd_bank", rd_bank, 1'b0);
        chk("swap_a_wr_bank", wr_bank, 1'b1);
        chk("swap_a_wr_ready", wr_ready, 1'b1);
        rd(13);
        chk("swap_a_re13", rd_re, 16'sd213);

        for (int k = 0; k < 13; k++) wr(300 + k, -(300 + k));
        rd_done = 1'b1;
        wr(313, -313);
        rd_done = 1'b0;
        chk("swap_b_frame_rdy", frame_rdy, 1'b1);
        chk("swap_b_rd_bank", rd_bank, 1'b1);
        chk("swap_b_wr_bank", wr_bank, 1'b0);
        chk("swap_b_wr_ready", wr_ready, 1'b1);
        rd(0);
        chk("swap_b_re0", rd_re, 16'sd300);
        chk("swap_b_im0", rd_im, -16'sd300);

        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("release_frame_rdy", frame_rdy, 1'b0);
        chk("release_rd_bank", rd_bank, 1'b0);
        rd(2);
        chk("empty_err", rd_err, 1'b1);
        chk("empty_valid", rd_valid, 1'b0);
        chk("empty_hold_re", rd_re, 16'sd300);
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("ignored_done_rd_bank", rd_bank, 1'b0);

        for (int k = 0; k < 7; k++) wr(k, k);
        chk("partial_wr_cnt", wr_cnt, 4'd7);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_wr_cnt", wr_cnt, 4'd0);
        chk("midrst_frame_rdy", frame_rdy, 1'b0);
        chk("midrst_wr_ready", wr_ready, 1'b1);
        chk("midrst_rd_re", rd_re, 16'sd0);
        for (int k = 0; k < 13; k++) wr(3 * k, -3 * k);
        chk("refill13_frame_rdy", frame_rdy, 1'b0);
        wr(39, -39);
        chk("refill_frame_rdy", frame_rdy, 1'b1);
        rd(7);
        chk("refill_re7", rd_re, 16'sd21);
        chk("refill_im7", rd_im, -16'sd21);
        chk("refill_valid", rd_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
